// File: rtl/riscv_fetch_pkg.sv
// -----------------------------------------------------------------------------
// riscv_fetch_pkg
//   Shared definitions for the instruction-fetch front end:
//     NOP_INSTR      canonical NOP (addi x0,x0,0), the payload of a trap marker
//     fetch_state_e  fetch sequencing states {RUN, TRAP, IDLE}
//     is_misaligned  true when a fetch target is not 4-byte aligned
// -----------------------------------------------------------------------------
package riscv_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN  = 2'd0,  // normal fetching
    TRAP = 2'd1,  // presenting a misaligned-target marker to decode
    IDLE = 2'd2   // marker consumed, waiting for the next redirect
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage : riscv_fetch_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Circular buffer of DEPTH entries {pc, instr, filled} sitting between the
//   instruction-memory channel and decode. An entry is allocated (pc written,
//   filled cleared) when a request is accepted, filled in order as responses
//   return, and released when decode consumes it. flush_i empties the queue.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_i               drop every entry and zero all pointers
//   alloc_i, alloc_pc_i   allocate the next entry for a request at alloc_pc_i
//   fill_i, fill_instr_i  write the oldest unfilled entry and mark it filled
//   pop_i                 release the head entry (decode handshake)
//   head_*_o              contents of the entry at the read pointer
//   count_o               allocated entries (filled or not, not yet consumed)
//   unfilled_o            allocated entries still awaiting their response
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     alloc_i,
  input  logic [XLEN-1:0]          alloc_pc_i,
  input  logic                     fill_i,
  input  logic [31:0]              fill_instr_i,
  input  logic                     pop_i,
  output logic                     head_filled_o,
  output logic [XLEN-1:0]          head_pc_o,
  output logic [31:0]              head_instr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   unfilled_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } payload_t;

  payload_t          mem_q [DEPTH];
  logic [DEPTH-1:0]  filled_q;
  logic [PW-1:0]     alloc_ptr_q;
  logic [PW-1:0]     fill_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     unfilled_q;

  // NOTE: payload storage is deliberately not reset; an entry is only ever
  // observed through filled_q, which is reset and flushed.
  always_ff @(posedge clk_i) begin
    if (alloc_i) mem_q[alloc_ptr_q].pc    <= alloc_pc_i;
    if (fill_i)  mem_q[fill_ptr_q].instr  <= fill_instr_i;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // read inside this block sees the pre-edge value regardless of order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      unfilled_q  <= '0;
    end else if (flush_i) begin
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      unfilled_q  <= '0;
    end else begin
      // Allocate, fill and pop always touch three distinct entries: the
      // allocated one is free, the filled one is unfilled, the popped one
      // is filled.
      if (alloc_i) begin
        filled_q[alloc_ptr_q] <= 1'b0;
        alloc_ptr_q           <= alloc_ptr_q + PW'(1);
      end
      if (fill_i) begin
        filled_q[fill_ptr_q] <= 1'b1;
        fill_ptr_q           <= fill_ptr_q + PW'(1);
      end
      if (pop_i) begin
        filled_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q           <= rd_ptr_q + PW'(1);
      end
      count_q    <= count_q + CW'(alloc_i) - CW'(pop_i);
      unfilled_q <= unfilled_q + CW'(alloc_i) - CW'(fill_i);
    end
  end

  assign head_filled_o = filled_q[rd_ptr_q];
  assign head_pc_o     = mem_q[rd_ptr_q].pc;
  assign head_instr_o  = mem_q[rd_ptr_q].instr;
  assign count_o       = count_q;
  assign unfilled_o    = unfilled_q;

endmodule : fetch_queue

// File: rtl/riscv_fetch_unit.sv
// -----------------------------------------------------------------------------
// riscv_fetch_unit
//   Instruction-fetch front end. Issues sequential fetch requests with several
//   in flight, buffers in-order responses with their PCs in fetch_queue, and
//   hands instructions to decode. A redirect flushes the queue, schedules the
//   still-outstanding responses to be discarded (drop counter) and restarts
//   fetch at the target; a misaligned target instead produces a single trap
//   marker (NOP, misaligned_out=1) and then idles until the next redirect.
//
// Ports:
//   clk_in, rst_in                  clock, asynchronous active-high reset
//   redirect_in, redirect_pc_in     branch/jump/trap redirect strobe + target
//   imem_req_valid_out/ready_in     request handshake, imem_addr_out = address
//   imem_rsp_valid_in, _data_in     in-order responses, always accepted
//   instr_valid_out/ready_in        decode handshake
//   instr_out, instr_pc_out         instruction and its PC
//   misaligned_out                  current instr_out is a trap marker
//   buf_count_out                   allocated queue entries
//
// Build option:
//   FETCH_PERF_CNT_EN  adds stall_req_cnt_out (request-stall cycles) and
//                      drop_cnt_out (discarded responses), both saturating.
// -----------------------------------------------------------------------------
module riscv_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     BUF_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        redirect_in,
  input  logic [XLEN-1:0]             redirect_pc_in,
  output logic                        imem_req_valid_out,
  input  logic                        imem_req_ready_in,
  output logic [XLEN-1:0]             imem_addr_out,
  input  logic                        imem_rsp_valid_in,
  input  logic [31:0]                 imem_rsp_data_in,
  output logic                        instr_valid_out,
  input  logic                        instr_ready_in,
  output logic [31:0]                 instr_out,
  output logic [XLEN-1:0]             instr_pc_out,
  output logic                        misaligned_out,
  output logic [$clog2(BUF_DEPTH):0]  buf_count_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                 stall_req_cnt_out,
  output logic [31:0]                 drop_cnt_out
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

  fetch_state_e    state_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] trap_pc_q;
  logic [CW-1:0]   drop_q;      // responses still owed for flushed requests
  logic [CW-1:0]   drop_redir;  // drop_q after a redirect this cycle
  logic [CW-1:0]   pending;     // every response the memory still owes

  logic            head_filled;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   q_unfilled;
  logic [CW:0]     budget_used;

  logic req_fire;
  logic rsp_fill;
  logic rsp_drop;
  logic q_pop;

  // Queue entries plus owed stale responses may never exceed the depth, so
  // a stale response can never land in a freshly allocated entry's slot.
  assign budget_used = {1'b0, q_count} + {1'b0, drop_q};

  // rst_in keeps the request quiet while reset is held.
  assign imem_req_valid_out = !rst_in && (state_q == RUN) && !redirect_in &&
                              (budget_used < DEPTH_C);
  assign imem_addr_out      = fetch_pc_q;
  assign req_fire           = imem_req_valid_out && imem_req_ready_in;

  // Stale responses come back first (in order), so any response while
  // drop_q is nonzero belongs to a flushed request.
  assign rsp_drop = imem_rsp_valid_in && (drop_q != '0);
  assign rsp_fill = imem_rsp_valid_in && !redirect_in && (drop_q == '0) &&
                    (q_unfilled != '0);
  assign q_pop    = (state_q == RUN) && head_filled && instr_ready_in &&
                    !redirect_in;

  // A response arriving with the redirect retires one owed response; the
  // guard ignores a spurious response when nothing is outstanding.
  assign pending    = drop_q + q_unfilled;
  assign drop_redir = pending - CW'(imem_rsp_valid_in && (pending != '0));

  fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_queue (
    .clk_i         (clk_in),
    .rst_i         (rst_in),
    .flush_i       (redirect_in),
    .alloc_i       (req_fire),
    .alloc_pc_i    (fetch_pc_q),
    .fill_i        (rsp_fill),
    .fill_instr_i  (imem_rsp_data_in),
    .pop_i         (q_pop),
    .head_filled_o (head_filled),
    .head_pc_o     (head_pc),
    .head_instr_o  (head_instr),
    .count_o       (q_count),
    .unfilled_o    (q_unfilled)
  );

  // Redirect has priority over every other update in the cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      trap_pc_q  <= '0;
      drop_q     <= '0;
    end else if (redirect_in) begin
      state_q    <= is_misaligned(redirect_pc_in[1:0]) ? TRAP : RUN;
      fetch_pc_q <= redirect_pc_in;
      trap_pc_q  <= redirect_pc_in;
      drop_q     <= drop_redir;
    end else begin
      if (req_fire) fetch_pc_q <= fetch_pc_q + XLEN'(4);
      if (rsp_drop) drop_q     <= drop_q - CW'(1);
      if (state_q == TRAP && instr_ready_in) state_q <= IDLE;
    end
  end

  // Decode-side view, decoded straight from registered state.
  // NOTE: every output gets a default before the case, so no path through
  // this block can leave a value unassigned and infer a latch.
  always_comb begin
    instr_valid_out = 1'b0;
    misaligned_out  = 1'b0;
    instr_out       = '0;
    instr_pc_out    = '0;
    unique case (state_q)
      TRAP: begin
        instr_valid_out = 1'b1;
        misaligned_out  = 1'b1;
        instr_out       = NOP_INSTR;
        instr_pc_out    = trap_pc_q;
      end
      RUN: begin
        if (head_filled) begin
          instr_valid_out = 1'b1;
          instr_out       = head_instr;
          instr_pc_out    = head_pc;
        end
      end
      default: ;
    endcase
  end

  assign buf_count_out = q_count;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] drop_evt_cnt_q;
  logic        drop_evt;

  assign drop_evt = redirect_in ? (imem_rsp_valid_in && (pending != '0))
                                : rsp_drop;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_cnt_q    <= '0;
      drop_evt_cnt_q <= '0;
    end else begin
      if (imem_req_valid_out && !imem_req_ready_in && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (drop_evt && (drop_evt_cnt_q != '1))
        drop_evt_cnt_q <= drop_evt_cnt_q + 32'd1;
    end
  end

  assign stall_req_cnt_out = stall_cnt_q;
  assign drop_cnt_out      = drop_evt_cnt_q;
`endif

endmodule : riscv_fetch_unit

// File: tb/tb_riscv_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_riscv_fetch_unit
//   Drives riscv_fetch_unit with directed scenarios and a randomized phase.
//   The reference model is transaction-level: a queue of requests the memory
//   still owes (tagged with the redirect epoch they belong to), a count of
//   live instructions delivered but not yet decoded, and the next PC decode
//   must see. Every cycle the bench compares the DUT against it.
// -----------------------------------------------------------------------------
module tb_riscv_fetch_unit;

  localparam int D = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = '0;
  logic        imem_req_valid_out;
  logic        imem_req_ready_in = 1'b0;
  logic [31:0] imem_addr_out;
  logic        imem_rsp_valid_in = 1'b0;
  logic [31:0] imem_rsp_data_in = '0;
  logic        instr_valid_out;
  logic        instr_ready_in = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        misaligned_out;
  logic [2:0]  buf_count_out;

  riscv_fetch_unit #(
    .XLEN      (32),
    .BUF_DEPTH (D),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .redirect_in        (redirect_in),
    .redirect_pc_in     (redirect_pc_in),
    .imem_req_valid_out (imem_req_valid_out),
    .imem_req_ready_in  (imem_req_ready_in),
    .imem_addr_out      (imem_addr_out),
    .imem_rsp_valid_in  (imem_rsp_valid_in),
    .imem_rsp_data_in   (imem_rsp_data_in),
    .instr_valid_out    (instr_valid_out),
    .instr_ready_in     (instr_ready_in),
    .instr_out          (instr_out),
    .instr_pc_out       (instr_pc_out),
    .misaligned_out     (misaligned_out),
    .buf_count_out      (buf_count_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    int          ep;
    int          t;
  } req_t;

  req_t        mem_q[$];      // requests the memory still owes, oldest first
  int          epoch = 0;     // bumped by redirect and reset
  int          cyc = 0;
  int          buffered = 0;  // live instructions delivered, not yet decoded
  logic [31:0] exp_req_pc = '0;
  logic [31:0] exp_dec_pc = '0;
  logic [31:0] trap_pc = '0;
  bit          trap = 1'b0;
  bit          idle = 1'b0;
  int          handshakes = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic int live_out();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].ep == epoch) n++;
    return n;
  endfunction

  // One clock cycle: drive at the falling edge, check 1 ns later, update the
  // model from the handshakes that occur at the following rising edge.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy,
                       input int rsp_pct, input bit dec_rdy);
    req_t        r;
    bit          rsp;
    bit          rsp_live;
    bit          exp_rv;
    bit          exp_iv;
    bit          req_fire;
    bit          dec_fire;
    logic [31:0] addr_s;
    int          lo;
    @(negedge clk_in);
    rsp = 1'b0;
    rsp_live = 1'b0;
    r = '{pc: '0, ep: -1, t: 0};
    if (mem_q.size() > 0 && mem_q[0].t < cyc && $urandom_range(99) < rsp_pct) begin
      r = mem_q.pop_front();
      rsp = 1'b1;
      rsp_live = (r.ep == epoch);
    end
    redirect_in       = redir;
    redirect_pc_in    = rpc;
    imem_req_ready_in = rdy;
    imem_rsp_valid_in = rsp;
    imem_rsp_data_in  = rsp ? mem_word(r.pc) : $urandom;
    instr_ready_in    = dec_rdy;
    #1;
    exp_rv = !trap && !idle && !redir &&
             (mem_q.size() + (rsp ? 1 : 0) + buffered) < D;
    check("req_valid", imem_req_valid_out, exp_rv);
    if (exp_rv && imem_req_valid_out) check("req_addr", imem_addr_out, exp_req_pc);
    exp_iv = trap || (!idle && buffered > 0);
    check("instr_valid", instr_valid_out, exp_iv);
    check("misaligned", misaligned_out, trap);
    lo = live_out() + (rsp_live ? 1 : 0);
    check("buf_count", buf_count_out, lo + buffered);
    if (exp_iv && instr_valid_out) begin
      if (trap) begin
        check("trap_pc", instr_pc_out, trap_pc);
        check("trap_instr", instr_out, 32'h0000_0013);
      end else begin
        check("instr_pc", instr_pc_out, exp_dec_pc);
        check("instr_word", instr_out, mem_word(exp_dec_pc));
      end
    end
    req_fire = imem_req_valid_out && rdy;
    dec_fire = instr_valid_out && dec_rdy;
    addr_s   = imem_addr_out;
    @(posedge clk_in);
    if (redir) begin
      epoch++;
      buffered   = 0;
      exp_req_pc = rpc;
      exp_dec_pc = rpc;
      trap_pc    = rpc;
      trap       = (rpc[1:0] != 2'b00);
      idle       = 1'b0;
    end else begin
      if (req_fire) begin
        mem_q.push_back('{pc: addr_s, ep: epoch, t: cyc});
        exp_req_pc += 32'd4;
      end
      if (rsp_live) buffered++;
      if (dec_fire) begin
        if (trap) begin
          trap = 1'b0;
          idle = 1'b1;
        end else if (buffered > 0) begin
          buffered--;
          exp_dec_pc += 32'd4;
          handshakes++;
        end
      end
    end
    cyc++;
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic apply_reset();
    @(negedge clk_in);
    #2;
    rst_in            = 1'b1;
    redirect_in       = 1'b0;
    imem_rsp_valid_in = 1'b0;
    imem_req_ready_in = 1'b0;
    instr_ready_in    = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid_out, 1'b0);
    check("rst_instr_valid", instr_valid_out, 1'b0);
    check("rst_misaligned", misaligned_out, 1'b0);
    check("rst_buf_count", buf_count_out, 3'd0);
    check("rst_instr", instr_out, 32'd0);
    check("rst_instr_pc", instr_pc_out, 32'd0);
    check("rst_addr", imem_addr_out, 32'h0000_0000);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    mem_q.delete();
    epoch++;
    buffered   = 0;
    exp_req_pc = 32'h0000_0000;
    exp_dec_pc = 32'h0000_0000;
    trap       = 1'b0;
    idle       = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  h5;
    int  h15;
    bit  found;
    logic [31:0] rpc;

    apply_reset();

    // Streaming with 1-cycle latency: one instruction per cycle once primed.
    h5 = 0;
    h15 = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, '0, 1'b1, 100, 1'b1);
      if (i == 5)  h5  = handshakes;
      if (i == 15) h15 = handshakes;
    end
    check("stream_rate", h15 - h5, 10);

    // Decode stalled: queue fills to depth and requests stop.
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 100, 1'b0);
    #1;
    check("full_count", buf_count_out, 3'd4);
    check("full_stall", imem_req_valid_out, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 100, 1'b1);

    // Requests in flight, then redirect to 0x100.
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 0, 1'b1);
    cycle(1'b1, 32'h0000_0100, 1'b1, 0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle(1'b0, '0, 1'b1, 100, 1'b0);
      #1;
      if (instr_valid_out) found = 1'b1;
    end
    check("redir_seen", found, 1'b1);
    check("redir_first_pc", instr_pc_out, 32'h0000_0100);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 100, 1'b1);

    // Redirect coincident with a response and a decode handshake.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (buffered > 0 && mem_q.size() > 0 && mem_q[0].t < cyc) found = 1'b1;
      else cycle(1'b0, '0, 1'b1, 50, 1'b0);
    end
    check("coincide_setup", found, 1'b1);
    cycle(1'b1, 32'h0000_0200, 1'b1, 100, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 70, 1'b1);

    // Misaligned target: held marker, then idle, then resume at 0x300.
    cycle(1'b1, 32'h0000_0102, 1'b1, 100, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 100, 1'b0);
    #1;
    check("marker_valid", instr_valid_out, 1'b1);
    check("marker_flag", misaligned_out, 1'b1);
    check("marker_pc", instr_pc_out, 32'h0000_0102);
    check("marker_instr", instr_out, 32'h0000_0013);
    cycle(1'b0, '0, 1'b1, 100, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 100, 1'b1);
    cycle(1'b1, 32'h0000_0300, 1'b1, 100, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 100, 1'b1);

    // Fetch PC wrap at the top of the address space.
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 100, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 100, 1'b1);

    // Randomized traffic with occasional redirects and one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset();
      rpc = $urandom & 32'h0000_0FFC;
      if ($urandom_range(3) == 0) rpc[1:0] = 2'($urandom_range(3, 1));
      cycle($urandom_range(63) == 0, rpc, $urandom_range(3) != 0,
            60, $urandom_range(3) != 0);
    end

    // Reset mid-burst, then restart from RESET_PC with an empty queue.
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 100, 1'b1);
    apply_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_riscv_fetch_unit

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation pipelined core.
- Replaces the single-register PC stage and the fixed combinational instruction-memory address.
- Issues instruction-memory requests over a valid/ready channel with multiple requests in flight.
- Buffers returned instructions with their PCs in a BUF_DEPTH-entry queue, flushes on redirect, and presents instructions to decode over a valid/ready handshake.

Parameters:
XLEN, 32, PC/address width
BUF_DEPTH, 4, queue entries = max in-flight plus buffered instructions (power of 2, >=2)
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  reset; asynchronous, active-high
redirect_in  input  1  branch/jump/trap redirect strobe
redirect_pc_in  input  XLEN  redirect target
imem_req_valid_out  output  1  fetch request valid
imem_req_ready_in  input  1  memory accepts request
imem_addr_out  output  XLEN  fetch address
imem_rsp_valid_in  input  1  in-order response valid (always accepted)
imem_rsp_data_in  input  32  instruction word
instr_valid_out  output  1  instruction to decode valid
instr_ready_in  input  1  decode accepts
instr_out  output  32  instruction
instr_pc_out  output  XLEN  PC of instr_out
misaligned_out  output  1  instr_out is a misaligned-target trap marker
buf_count_out  output  $clog2(BUF_DEPTH)+1  allocated entries

Behaviour:
- Reset values (asynchronous): fetch_pc=RESET_PC, all pointers 0, drop_cnt=0, state RUN, all outputs 0, imem_addr_out=RESET_PC.
- Queue structure: circular, BUF_DEPTH entries {pc, instr, filled}.
  - alloc_ptr advances on request acceptance; the entry's pc is written and filled=0.
  - fill_ptr advances on each non-dropped response, writing instr and setting filled=1.
  - rd_ptr advances on the decode handshake.
  - Pointers wrap modulo BUF_DEPTH.
- Request issue:
  - imem_req_valid_out = (state==RUN) && !redirect_in && (alloc_count + drop_cnt) < BUF_DEPTH.
  - imem_addr_out = fetch_pc.
  - On valid&&ready: fetch_pc += 4 (wraps at 2^XLEN) and an entry is allocated.
- Response rules:
  - Responses arrive in order, at least 1 cycle after acceptance.
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - A response with no outstanding request is ignored.
- Decode output:
  - instr_valid_out = entry[rd_ptr].filled; instr_out and instr_pc_out come from entry[rd_ptr].
  - Same-cycle fill of rd entry: the instruction is visible the next cycle (registered output, no bypass).
- Full queue (alloc_count==BUF_DEPTH): request stalls and fetch_pc is held.
- Simultaneous issue, fill and consume in one cycle are all legal.
- Redirect (single-cycle strobe, highest priority):
  - All entries are invalidated and pointers reset to 0.
  - drop_cnt <= drop_cnt + (allocated-unfilled) - (imem_rsp_valid_in ? 1 : 0). A response in the redirect cycle is itself discarded.
  - fetch_pc <= redirect_pc_in.
  - instr_valid_out is 0 in the next cycle.
  - The first new request issues in the cycle after redirect.
- FSM:
  - RUN: normal fetch. Redirect with redirect_pc_in[1:0]!=0 -> TRAP.
  - TRAP: no requests. Output instr_valid_out=1, misaligned_out=1, instr_out=32'h0000_0013, instr_pc_out=target, held until handshake -> IDLE.
  - IDLE: no requests, instr_valid_out=0.
  - Any redirect in any state re-evaluates alignment (-> RUN or TRAP).
- Reset mid-operation discards all state. The instruction memory shares rst_in, so no responses arrive after reset for pre-reset requests.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs stall_req_cnt_out[31:0], counting cycles where imem_req_valid_out && !imem_req_ready_in, and drop_cnt_out[31:0], counting discarded responses.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package riscv_fetch_pkg holds:
  - NOP_INSTR = 32'h0000_0013.
  - Fetch state enum {RUN, TRAP, IDLE}.
  - Entry struct {pc, instr, filled}.
- Sub-module fetch_queue (circular buffer with alloc/fill/read pointers and flush) is natural; FSM, PC and drop logic stay in the top.

Test Plan:
- Reset release, ready=1, 1-cycle response latency, decode ready -> addresses 0x0, 0x4, 0x8...; instr_pc_out matches; sustained 1 instr/cycle after 2-cycle fill.
- instr_ready_in=0 for 10 cycles -> exactly BUF_DEPTH (4) requests issued, then imem_req_valid_out=0, buf_count_out=4; release -> drains in order.
- 3 requests in flight, redirect to 0x100 -> next 3 responses discarded, first delivered instr_pc_out=0x100, no stale PC ever valid.
- Redirect coincident with a response and with instr handshake -> that response dropped, drop_cnt correct, no duplicate or lost instruction at 0x200.
- Redirect to 0x102 -> no requests; one marker with misaligned_out=1, pc=0x102, instr=0x13; after handshake idle; redirect to 0x300 resumes.
- Assert rst_in mid-burst -> outputs 0 immediately (asynchronous); after release fetch restarts at RESET_PC with empty queue.
